// File: rtl/cpu_mem_pkg.sv
// Shared memory types and default geometry for the CPU instruction/data memories.
package cpu_mem_pkg;

   localparam int unsigned DMB_DATA_W = 16;
   localparam int unsigned DMB_ADDR_W = 4;
   localparam int unsigned DMB_NUM_RD = 2;

   typedef enum logic {
      DMB_IDLE  = 1'b0,
      DMB_CLEAR = 1'b1
   } dmb_state_t;

endpackage : cpu_mem_pkg

// File: rtl/data_memory_bank_if.sv
// Write/read/status bundle between the CPU datapath (master) and the data memory bank (slave).
interface data_memory_bank_if #(
   parameter int unsigned DATA_W = cpu_mem_pkg::DMB_DATA_W,
   parameter int unsigned ADDR_W = cpu_mem_pkg::DMB_ADDR_W,
   parameter int unsigned NUM_RD = cpu_mem_pkg::DMB_NUM_RD
);

   logic                       load;
   logic                       is_instruction;
   logic [ADDR_W-1:0]          load_address;
   logic [DATA_W-1:0]          cpu_input;
   logic                       err_inject;
   logic                       clear_req;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]          parity_err;
   logic                       busy;
   logic                       load_accepted;

   modport master (
      output load, is_instruction, load_address, cpu_input, err_inject, clear_req, rd_addr,
      input  rd_data, parity_err, busy, load_accepted
   );

   modport slave (
      input  load, is_instruction, load_address, cpu_input, err_inject, clear_req, rd_addr,
      output rd_data, parity_err, busy, load_accepted
   );

endinterface : data_memory_bank_if

// File: rtl/dmem_clear_seq.sv
// Clear sequencer: sweeps every word to zero after reset and on clear_req.
module dmem_clear_seq #(
   parameter int unsigned ADDR_W = cpu_mem_pkg::DMB_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req,
   output logic              clr_we_c,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              busy
);
   import cpu_mem_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   dmb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              busy_q, busy_d;

   // Next-state: sweep one word per cycle, return to IDLE after the last word.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         DMB_IDLE: begin
            if (clear_req) state_d = DMB_CLEAR;
         end
         DMB_CLEAR: begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LAST_ADDR) state_d = DMB_IDLE;
         end
         default: state_d = DMB_IDLE;
      endcase
      busy_d = (state_d == DMB_CLEAR);
   end

   // State, pointer and busy registers; reset starts a fresh sweep from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DMB_CLEAR;
         clr_ptr_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         busy_q    <= busy_d;
      end
   end

   assign clr_we_c = (state_q == DMB_CLEAR);
   assign clr_addr = clr_ptr_q;
   assign busy     = busy_q;

endmodule : dmem_clear_seq

// File: rtl/data_memory_bank.sv
// Parametrised CPU data memory: one write port, NUM_RD combinational read ports,
// hardware clear sweep and write-accept pulse.
// Optional per-word even parity: define DATA_MEMORY_BANK_PARITY_EN.
module data_memory_bank #(
   parameter int unsigned DATA_W = cpu_mem_pkg::DMB_DATA_W,
   parameter int unsigned ADDR_W = cpu_mem_pkg::DMB_ADDR_W,
   parameter int unsigned NUM_RD = cpu_mem_pkg::DMB_NUM_RD
) (
   input logic               clk,
   input logic               rst_n,
   data_memory_bank_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        mem_q [DEPTH];
   logic                     clr_we_c;
   logic [ADDR_W-1:0]        clr_addr;
   logic                     busy;
   logic                     load_accepted_q, load_accepted_d;
   logic                     wr_en_c;
   logic [ADDR_W-1:0]        wr_addr_c;
   logic [DATA_W-1:0]        wr_data_c;
   logic                     wr_par_c;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        parity_err_c;

   dmem_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_req (bus.clear_req),
      .clr_we_c  (clr_we_c),
      .clr_addr  (clr_addr),
      .busy      (busy)
   );

   // Write port mux: the sweep owns the array while busy, otherwise data writes.
   always_comb begin
      load_accepted_d = bus.load && !bus.is_instruction && !busy;
      wr_en_c         = clr_we_c || load_accepted_d;
      wr_addr_c       = bus.load_address;
      wr_data_c       = bus.cpu_input;
      wr_par_c        = (^bus.cpu_input) ^ bus.err_inject;
      if (clr_we_c) begin
         wr_addr_c = clr_addr;
         wr_data_c = '0;
         wr_par_c  = 1'b0;
      end
   end

   // Storage array; intentionally not reset, the sweep zeroes it.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[wr_addr_c] <= wr_data_c;
   end

   // One-cycle pulse marking a committed data write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) load_accepted_q <= 1'b0;
      else        load_accepted_q <= load_accepted_d;
   end

`ifdef DATA_MEMORY_BANK_PARITY_EN
   logic par_q [DEPTH];

   // Parity bit array, written alongside the data word.
   always_ff @(posedge clk) begin
      if (wr_en_c) par_q[wr_addr_c] <= wr_par_c;
   end

   // Read ports: zero while sweeping, parity compared on the addressed word.
   always_comb begin
      rd_data_c    = '0;
      parity_err_c = '0;
      if (!busy) begin
         for (int k = 0; k < int'(NUM_RD); k++) begin
            rd_data_c[k*DATA_W +: DATA_W] = mem_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
            parity_err_c[k] = (^mem_q[bus.rd_addr[k*ADDR_W +: ADDR_W]])
                              != par_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
         end
      end
   end
`else
   logic unused_par_c;
   assign unused_par_c = wr_par_c;

   // Read ports: zero while sweeping; no parity storage in this build.
   always_comb begin
      rd_data_c    = '0;
      parity_err_c = '0;
      if (!busy) begin
         for (int k = 0; k < int'(NUM_RD); k++) begin
            rd_data_c[k*DATA_W +: DATA_W] = mem_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
         end
      end
   end
`endif

   assign bus.rd_data       = rd_data_c;
   assign bus.parity_err    = parity_err_c;
   assign bus.busy          = busy;
   assign bus.load_accepted = load_accepted_q;

endmodule : data_memory_bank

// File: tb/tb_data_memory_bank.sv
// Directed self-checking bench for data_memory_bank (default 16x16, 2 read ports).
module tb_data_memory_bank;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n;

   data_memory_bank_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) dmb_if ();

   data_memory_bank #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dmb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Counts edges until busy drops (bounded); holds load, checks no accept while busy,
   // and pulses clear_req for one cycle when the count equals pulse_at.
   task automatic wait_sweep(input int pulse_at, output int cnt);
      cnt = 0;
      while (dmb_if.busy === 1'b1 && cnt < 40) begin
         dmb_if.clear_req = (cnt == pulse_at);
         @(posedge clk);
         #1;
         cnt++;
         if (dmb_if.load === 1'b1) chk("no_accept_busy", 32'(dmb_if.load_accepted), 32'd0);
      end
      dmb_if.clear_req = 1'b0;
   endtask

   task automatic write_word(input logic [3:0] a, input logic [15:0] d);
      dmb_if.load         = 1'b1;
      dmb_if.load_address = a;
      dmb_if.cpu_input    = d;
      @(posedge clk);
      #1;
      dmb_if.load = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      dmb_if.load           = 1'b0;
      dmb_if.is_instruction = 1'b0;
      dmb_if.load_address   = '0;
      dmb_if.cpu_input      = '0;
      dmb_if.err_inject     = 1'b0;
      dmb_if.clear_req      = 1'b0;
      dmb_if.rd_addr        = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(dmb_if.busy), 32'd1);
      chk("rst_la", 32'(dmb_if.load_accepted), 32'd0);
      chk("rst_rd", 32'(dmb_if.rd_data), 32'd0);

      // Post-reset sweep length
      rst_n = 1'b1;
      wait_sweep(-1, n);
      chk("reset_sweep_len", 32'(n), 32'd16);

      // All words cleared
      for (int i = 0; i < 16; i++) begin
         dmb_if.rd_addr = {4'(15 - i), 4'(i)};
         #0.1;
         chk("clr_rd_all", 32'(dmb_if.rd_data), 32'd0);
      end
      @(posedge clk);
      #1;

      // Read-before-write at address 5
      dmb_if.rd_addr      = {4'd0, 4'd5};
      dmb_if.load         = 1'b1;
      dmb_if.load_address = 4'd5;
      dmb_if.cpu_input    = 16'hBEEF;
      #1;
      chk("rbw_old", 32'(dmb_if.rd_data[15:0]), 32'h0000);
      chk("la_before", 32'(dmb_if.load_accepted), 32'd0);
      @(posedge clk);
      #1;
      chk("rbw_new", 32'(dmb_if.rd_data[15:0]), 32'hBEEF);
      chk("la_pulse", 32'(dmb_if.load_accepted), 32'd1);
      dmb_if.load = 1'b0;
      @(posedge clk);
      #1;
      chk("la_one_cycle", 32'(dmb_if.load_accepted), 32'd0);

      // Instruction-targeted write is dropped
      dmb_if.is_instruction = 1'b1;
      write_word(4'd3, 16'h1234);
      chk("instr_la", 32'(dmb_if.load_accepted), 32'd0);
      dmb_if.is_instruction = 1'b0;
      dmb_if.rd_addr = {4'd3, 4'd5};
      #1;
      chk("instr_mem3", 32'(dmb_if.rd_data[31:16]), 32'h0000);
      chk("mem5_kept", 32'(dmb_if.rd_data[15:0]), 32'hBEEF);

      // Write 7, then clear with loads and a second clear_req during the sweep
      write_word(4'd7, 16'hAAAA);
      dmb_if.rd_addr = {4'd0, 4'd7};
      #1;
      chk("mem7_written", 32'(dmb_if.rd_data[15:0]), 32'hAAAA);
      dmb_if.clear_req = 1'b1;
      @(posedge clk);
      #1;
      dmb_if.clear_req = 1'b0;
      chk("clr_busy", 32'(dmb_if.busy), 32'd1);
      chk("clr_rd_masked", 32'(dmb_if.rd_data), 32'd0);
      dmb_if.load         = 1'b1;
      dmb_if.load_address = 4'd10;
      dmb_if.cpu_input    = 16'h1111;
      wait_sweep(3, n);
      dmb_if.load = 1'b0;
      chk("clr_sweep_len", 32'(n), 32'd16);
      dmb_if.rd_addr = {4'd10, 4'd7};
      #1;
      chk("clr_mem7", 32'(dmb_if.rd_data[15:0]), 32'h0000);
      chk("clr_mem10_dropped", 32'(dmb_if.rd_data[31:16]), 32'h0000);
      @(posedge clk);
      #1;

      // Same-cycle load + clear_req
      dmb_if.load         = 1'b1;
      dmb_if.load_address = 4'd2;
      dmb_if.cpu_input    = 16'h5555;
      dmb_if.clear_req    = 1'b1;
      @(posedge clk);
      #1;
      dmb_if.load      = 1'b0;
      dmb_if.clear_req = 1'b0;
      chk("simul_la", 32'(dmb_if.load_accepted), 32'd1);
      chk("simul_busy", 32'(dmb_if.busy), 32'd1);
      wait_sweep(-1, n);
      chk("simul_sweep_len", 32'(n), 32'd16);
      dmb_if.rd_addr = {4'd2, 4'd2};
      #1;
      chk("simul_mem2", 32'(dmb_if.rd_data), 32'h0000_0000);

      // Boundary addresses and shared-address reads
      write_word(4'd15, 16'hF00D);
      write_word(4'd0, 16'h0D0D);
      write_word(4'd12, 16'h1357);
      dmb_if.rd_addr = {4'd15, 4'd15};
      #1;
      chk("same_addr_15", 32'(dmb_if.rd_data), 32'hF00D_F00D);
      dmb_if.rd_addr = {4'd12, 4'd0};
      #1;
      chk("addr0_addr12", 32'(dmb_if.rd_data), 32'h1357_0D0D);

      // Parity error injection
      dmb_if.err_inject = 1'b1;
      write_word(4'd9, 16'h00FF);
      dmb_if.err_inject = 1'b0;
      dmb_if.rd_addr = {4'd9, 4'd9};
      #1;
      chk("par_data9", 32'(dmb_if.rd_data), 32'h00FF_00FF);
`ifdef DATA_MEMORY_BANK_PARITY_EN
      chk("par_err_inj", 32'(dmb_if.parity_err), 32'd3);
      dmb_if.rd_addr = {4'd9, 4'd12};
      #1;
      chk("par_err_port1", 32'(dmb_if.parity_err), 32'd2);
      write_word(4'd9, 16'h00FF);
      dmb_if.rd_addr = {4'd9, 4'd9};
      #1;
      chk("par_err_clean", 32'(dmb_if.parity_err), 32'd0);
`else
      chk("par_err_tied", 32'(dmb_if.parity_err), 32'd0);
`endif

      // Reset mid-sweep restarts from word 0
      dmb_if.clear_req = 1'b1;
      @(posedge clk);
      #1;
      dmb_if.clear_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(dmb_if.busy), 32'd1);
      chk("midrst_la", 32'(dmb_if.load_accepted), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_sweep(-1, n);
      chk("midrst_sweep_len", 32'(n), 32'd16);
      dmb_if.rd_addr = {4'd15, 4'd12};
      #1;
      chk("midrst_cleared", 32'(dmb_if.rd_data), 32'h0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_data_memory_bank
